// File: rtl/x86_bus_unit.sv
// Bus interface unit: arbitrates the byte-wide memory port between the core's
// data cycles and a free-running instruction prefetch queue.
module x86_bus_unit #(
   parameter int          QDEPTH     = 8,
   parameter logic [19:0] RESET_ADDR = 20'hFFFF0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   output logic [19:0]               address,
   input  logic [7:0]                in,
   output logic [7:0]                out,
   output logic                      wren,
   input  logic                      flush,
   input  logic [19:0]               flush_addr,
   output logic                      q_valid,
   output logic [7:0]                q_byte,
   input  logic                      q_pop,
   output logic [$clog2(QDEPTH):0]   q_count,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic                      d_word,
   input  logic [19:0]               d_addr,
   input  logic [15:0]               d_wdata,
   output logic [15:0]               d_rdata,
   output logic                      d_ack
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW+1:0] QDEPTH_W = (AW+2)'(QDEPTH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DLO  = 3'd1,
      ST_DHI  = 3'd2,
      ST_WAIT = 3'd3,
      ST_ACK  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [19:0]   fetch_ptr_q, fetch_ptr_d;
   logic          tag_q, tag_d;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    lo_q, lo_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          ack_q, ack_d;
   logic [7:0]    qmem_q [QDEPTH];

   logic [AW+1:0] room_sum_s;
   logic          issue_s;
   logic          cap_s;
   logic          pop_s;

   // The room check includes the byte already on its way back from memory.
   always_comb begin
      room_sum_s = {1'b0, count_q} + {{(AW+1){1'b0}}, tag_q};
      issue_s    = (state_q == ST_IDLE) && (room_sum_s < QDEPTH_W);
      cap_s      = tag_q && !flush;
      pop_s      = q_pop && (count_q != {(AW+1){1'b0}}) && !flush;
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (d_req) begin
               state_d = ST_DLO;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DLO: begin
            if (d_word) begin
               state_d = ST_DHI;
            end else if (d_we) begin
               state_d = ST_ACK;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DHI: begin
            if (d_we) begin
               state_d = ST_ACK;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: memory port drive.
   always_comb begin
      address = fetch_ptr_q;
      wren    = 1'b0;
      out     = 8'h00;
      case (state_q)
         ST_DLO: begin
            address = d_addr;
            wren    = d_we;
            out     = d_we ? d_wdata[7:0] : 8'h00;
         end
         ST_DHI: begin
            address = d_addr + 20'd1;
            wren    = d_we;
            out     = d_we ? d_wdata[15:8] : 8'h00;
         end
         default: begin
            address = fetch_ptr_q;
            wren    = 1'b0;
            out     = 8'h00;
         end
      endcase
   end

   // Data read assembly; the low byte of a word lands while the high address is out.
   always_comb begin
      lo_d    = lo_q;
      rdata_d = rdata_q;
      ack_d   = (state_d == ST_ACK);
      if ((state_q == ST_DHI) && !d_we) begin
         lo_d = in;
      end else begin
         lo_d = lo_q;
      end
      if (state_q == ST_WAIT) begin
         rdata_d = d_word ? {in, lo_q} : {8'h00, in};
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Prefetch queue control; flush drops the returning byte and any pop.
   always_comb begin
      fetch_ptr_d = fetch_ptr_q;
      tag_d       = 1'b0;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      if (flush) begin
         fetch_ptr_d = flush_addr;
         tag_d       = 1'b0;
         head_d      = {AW{1'b0}};
         tail_d      = {AW{1'b0}};
         count_d     = {(AW+1){1'b0}};
      end else begin
         fetch_ptr_d = issue_s ? (fetch_ptr_q + 20'd1) : fetch_ptr_q;
         tag_d       = issue_s;
         head_d      = pop_s ? (head_q + PTR_ONE) : head_q;
         tail_d      = cap_s ? (tail_q + PTR_ONE) : tail_q;
         count_d     = count_q + {{AW{1'b0}}, cap_s} - {{AW{1'b0}}, pop_s};
      end
   end

   // Datapath and queue pointer registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_ptr_q <= RESET_ADDR;
         tag_q       <= 1'b0;
         head_q      <= {AW{1'b0}};
         tail_q      <= {AW{1'b0}};
         count_q     <= {(AW+1){1'b0}};
         lo_q        <= 8'h00;
         rdata_q     <= 16'h0000;
         ack_q       <= 1'b0;
      end else begin
         fetch_ptr_q <= fetch_ptr_d;
         tag_q       <= tag_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         lo_q        <= lo_d;
         rdata_q     <= rdata_d;
         ack_q       <= ack_d;
      end
   end

   // Queue storage, written at the tail whenever a tagged byte returns.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            qmem_q[i] <= 8'h00;
         end
      end else begin
         if (cap_s) begin
            qmem_q[tail_q] <= in;
         end
      end
   end

   assign q_valid = (count_q != {(AW+1){1'b0}});
   assign q_byte  = qmem_q[head_q];
   assign q_count = count_q;
   assign d_rdata = rdata_q;
   assign d_ack   = ack_q;

endmodule

// File: tb/tb_x86_bus_unit.sv
// Directed bench for x86_bus_unit with a 1 MB registered-read memory model.
module tb_x86_bus_unit;

   logic        clock;
   logic        reset_n;
   logic [19:0] address;
   logic [7:0]  mem_rd;
   logic [7:0]  out;
   logic        wren;
   logic        flush;
   logic [19:0] flush_addr;
   logic        q_valid;
   logic [7:0]  q_byte;
   logic        q_pop;
   logic [3:0]  q_count;
   logic        d_req;
   logic        d_we;
   logic        d_word;
   logic [19:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_ack;

   logic [7:0]  mem [0:1048575];
   int          n_checks;
   int          n_errors;

   x86_bus_unit #(.QDEPTH(8), .RESET_ADDR(20'hFFFF0)) dut (
      .clock(clock), .reset_n(reset_n), .address(address), .in(mem_rd),
      .out(out), .wren(wren), .flush(flush), .flush_addr(flush_addr),
      .q_valid(q_valid), .q_byte(q_byte), .q_pop(q_pop), .q_count(q_count),
      .d_req(d_req), .d_we(d_we), .d_word(d_word), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: write on wren, registered read of the driven address.
   always @(posedge clock) begin
      if (wren) mem[address] <= out;
      mem_rd <= mem[address];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
      #1;
   endtask

   initial begin
      logic [7:0] boot [8];
      logic [19:0] wrap_a [4];
      logic [7:0] wrap_b [4];
      boot   = '{8'hEA, 8'h00, 8'h01, 8'h00, 8'hF0, 8'hAA, 8'hBB, 8'hCC};
      wrap_a = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
      wrap_b = '{8'h9C, 8'h34, 8'h12, 8'h5D};
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 1048576; i++) mem[i] = 8'(i ^ (i >> 8));
      for (int i = 0; i < 8; i++) mem[20'hFFFF0 + i] = boot[i];
      mem[20'hFFFFE] = 8'h9C; mem[20'hFFFFF] = 8'h34;
      mem[20'h00000] = 8'h12; mem[20'h00001] = 8'h5D;
      mem[20'h00010] = 8'h7F; mem[20'h00200] = 8'h77;
      mem[20'h00100] = 8'hA5; mem[20'h00101] = 8'h3C;
      mem[20'h00300] = 8'hE1; mem[20'h00301] = 8'hB6;
      mem_rd = 8'h00;
      reset_n = 1'b0; flush = 1'b0; flush_addr = 20'h0; q_pop = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_word = 1'b0; d_addr = 20'h0; d_wdata = 16'h0;

      // Reset values.
      cyc();
      chk("rst_addr", address, 20'hFFFF0);
      chk("rst_cnt", q_count, 4'd0);
      chk("rst_valid", q_valid, 1'b0);
      chk("rst_ack", d_ack, 1'b0);
      chk("rst_rdata", d_rdata, 16'h0000);
      chk("rst_wren", wren, 1'b0);
      chk("rst_out", out, 8'h00);

      // Boot prefetch fills the queue and stops.
      @(negedge clock); reset_n = 1'b1; #1;
      for (int i = 0; i < 8; i++) begin
         chk("boot_addr", address, 20'hFFFF0 + i);
         cyc();
      end
      repeat (4) cyc();
      chk("full_cnt", q_count, 4'd8);
      chk("full_noissue", address, 20'hFFFF8);
      chk("full_head", q_byte, 8'hEA);
      for (int i = 0; i < 8; i++) begin
         q_pop = 1'b1;
         chk("boot_byte", q_byte, boot[i]);
         cyc();
      end
      q_pop = 1'b0;

      // Flush to FFFFE, fetch wraps through 00000 under continuous pops.
      flush = 1'b1; flush_addr = 20'hFFFFE;
      cyc();
      flush = 1'b0; q_pop = 1'b1;
      chk("wrap_cnt0", q_count, 4'd0);
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) chk("wrap_addr", address, wrap_a[k-1]);
         if (k >= 3) chk("wrap_byte", q_byte, wrap_b[k-3]);
         cyc();
      end
      q_pop = 1'b0;

      // Word write while prefetching from 00200.
      flush = 1'b1; flush_addr = 20'h00200;
      cyc();
      flush = 1'b0;
      chk("ww_pfaddr", address, 20'h00200);
      d_req = 1'b1; d_we = 1'b1; d_word = 1'b1; d_addr = 20'h12345; d_wdata = 16'hBEEF;
      cyc();
      chk("ww_a1", address, 20'h12345);
      chk("ww_o1", out, 8'hEF);
      chk("ww_w1", wren, 1'b1);
      chk("ww_k1", d_ack, 1'b0);
      cyc();
      chk("ww_a2", address, 20'h12346);
      chk("ww_o2", out, 8'hBE);
      chk("ww_w2", wren, 1'b1);
      chk("ww_k2", d_ack, 1'b0);
      cyc();
      chk("ww_ack", d_ack, 1'b1);
      chk("ww_w3", wren, 1'b0);
      chk("ww_qcnt", q_count, 4'd1);
      chk("ww_qbyte", q_byte, 8'h77);
      d_req = 1'b0;
      cyc();
      chk("ww_ackoff", d_ack, 1'b0);
      chk("ww_resume", address, 20'h00201);
      cyc();
      chk("ww_mem_lo", mem[20'h12345], 8'hEF);
      chk("ww_mem_hi", mem[20'h12346], 8'hBE);

      // Word read across the top of memory.
      d_req = 1'b1; d_we = 1'b0; d_word = 1'b1; d_addr = 20'hFFFFF;
      cyc();
      chk("wr_a1", address, 20'hFFFFF);
      chk("wr_w1", wren, 1'b0);
      chk("wr_k1", d_ack, 1'b0);
      cyc();
      chk("wr_a2", address, 20'h00000);
      chk("wr_k2", d_ack, 1'b0);
      cyc();
      chk("wr_k3", d_ack, 1'b0);
      cyc();
      chk("wr_ack", d_ack, 1'b1);
      chk("wr_data", d_rdata, 16'h1234);
      d_req = 1'b0;
      cyc();
      chk("wr_ackoff", d_ack, 1'b0);
      chk("wr_hold", d_rdata, 16'h1234);

      // Byte read, zero-extended.
      d_req = 1'b1; d_word = 1'b0; d_addr = 20'h00010;
      cyc();
      chk("br_a1", address, 20'h00010);
      cyc();
      chk("br_k2", d_ack, 1'b0);
      cyc();
      chk("br_ack", d_ack, 1'b1);
      chk("br_data", d_rdata, 16'h007F);
      d_req = 1'b0;
      cyc();

      // Flush with pop in the cycle a prefetch byte returns.
      flush = 1'b1; flush_addr = 20'h00300;
      cyc();
      flush = 1'b0;
      chk("fl_a0", address, 20'h00300);
      cyc();
      cyc();
      chk("fl_pre_cnt", q_count, 4'd1);
      chk("fl_pre_byte", q_byte, 8'hE1);
      flush = 1'b1; flush_addr = 20'h00100; q_pop = 1'b1;
      cyc();
      flush = 1'b0; q_pop = 1'b0;
      chk("fl_cnt", q_count, 4'd0);
      chk("fl_valid", q_valid, 1'b0);
      chk("fl_addr", address, 20'h00100);
      cyc();
      chk("fl_addr2", address, 20'h00101);
      chk("fl_cnt2", q_count, 4'd0);
      cyc();
      chk("fl_cnt3", q_count, 4'd1);
      chk("fl_byte", q_byte, 8'hA5);

      // Reset during the high byte of a word read.
      d_req = 1'b1; d_we = 1'b0; d_word = 1'b1; d_addr = 20'h00050;
      cyc();
      cyc();
      chk("mr_dhi", address, 20'h00051);
      reset_n = 1'b0;
      #1;
      chk("mr_ack", d_ack, 1'b0);
      chk("mr_cnt", q_count, 4'd0);
      chk("mr_valid", q_valid, 1'b0);
      chk("mr_addr", address, 20'hFFFF0);
      chk("mr_rdata", d_rdata, 16'h0000);
      d_req = 1'b0;
      cyc();
      chk("mr_ack2", d_ack, 1'b0);
      reset_n = 1'b1;
      #1;
      chk("mr_rel_a0", address, 20'hFFFF0);
      cyc();
      chk("mr_rel_a1", address, 20'hFFFF1);
      chk("mr_ack3", d_ack, 1'b0);
      cyc();
      chk("mr_rel_cnt", q_count, 4'd1);
      chk("mr_rel_byte", q_byte, 8'hEA);
      chk("mr_ack4", d_ack, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
